axis_frame_gen: RTL and testbench

AXIS_FRAME_GEN -- requirements
Module: axis_frame_gen

---
 rtl/axis_frame_gen.sv | 178 +++++++++++++++++
 tb/tb_axis_frame_gen.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_gen.sv
// AXI4-Stream test-pattern frame generator: streams IMG_W x IMG_H pixels with
// SOF on tuser[0] and EOL on tlast. Every output comes straight from a flop.
package img_processing_pkg;
  localparam int IMG_W = 640;
  localparam int IMG_H = 480;

  typedef enum logic [1:0] {
    BYPASS = 2'd0,
    BOX    = 2'd1,
    GAUSS  = 2'd2,
    SOBEL  = 2'd3
  } kernel_type_t;
endpackage

module axis_frame_gen #(
  parameter int IMG_W            = img_processing_pkg::IMG_W,
  parameter int IMG_H            = img_processing_pkg::IMG_H,
  parameter int AXIS_TDATA_WIDTH = 8,
  parameter int AXIS_TUSER_WIDTH = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        continuous,
  input  logic [1:0]                  pattern,
  input  logic [7:0]                  const_val,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic [AXIS_TUSER_WIDTH-1:0] m_axis_tuser,
  output logic                        busy,
  output logic                        frame_done
);
  import img_processing_pkg::*;

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t                      state_q, state_d;
  logic [XW-1:0]               x_q, x_d;
  logic [YW-1:0]               y_q, y_d;
  kernel_type_t                pattern_q, pattern_d;
  logic [7:0]                  const_q, const_d;
  logic                        cont_q, cont_d;
  logic [AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                        tvalid_q, tvalid_d;
  logic                        tlast_q, tlast_d;
  logic [AXIS_TUSER_WIDTH-1:0] tuser_q, tuser_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;

  logic          hs, x_end, y_end;
  logic [XW-1:0] x_nxt;
  logic [YW-1:0] y_nxt;

  function automatic logic [7:0] pix(input kernel_type_t p, input logic [7:0] cv,
                                     input logic [7:0] x, input logic [7:0] y);
    case (p)
      BYPASS:  pix = cv;
      BOX:     pix = x;
      GAUSS:   pix = y;
      default: pix = (x[3] ^ y[3]) ? 8'hFF : 8'h00;
    endcase
  endfunction

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    pattern_d = pattern_q;
    const_d   = const_q;
    cont_d    = cont_q;
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    tuser_d   = tuser_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    hs    = tvalid_q & m_axis_tready;
    x_end = (x_q == XW'(IMG_W - 1));
    y_end = (y_q == YW'(IMG_H - 1));
    x_nxt = x_end ? '0 : x_q + 1'b1;
    y_nxt = x_end ? (y_end ? '0 : y_q + 1'b1) : y_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = STREAM;
          pattern_d = kernel_type_t'(pattern);
          const_d   = const_val;
          cont_d    = continuous;
          x_d       = '0;
          y_d       = '0;
          tdata_d   = AXIS_TDATA_WIDTH'(pix(kernel_type_t'(pattern), const_val, 8'd0, 8'd0));
          tvalid_d  = 1'b1;
          tlast_d   = 1'b0;
          tuser_d   = '0;
          tuser_d[0] = 1'b1;
          busy_d    = 1'b1;
        end
      end
      default: begin
        if (hs) begin
          x_d     = x_nxt;
          y_d     = y_nxt;
          tuser_d = '0;
          if (x_end && y_end) begin
            done_d = 1'b1;
            // The latched mode allows repetition; the live input can still stop it.
            if (cont_q && continuous) begin
              pattern_d  = kernel_type_t'(pattern);
              const_d    = const_val;
              cont_d     = continuous;
              tdata_d    = AXIS_TDATA_WIDTH'(pix(kernel_type_t'(pattern), const_val, 8'd0, 8'd0));
              tlast_d    = 1'b0;
              tuser_d[0] = 1'b1;
            end else begin
              state_d  = IDLE;
              tdata_d  = '0;
              tvalid_d = 1'b0;
              tlast_d  = 1'b0;
              busy_d   = 1'b0;
            end
          end else begin
            tdata_d = AXIS_TDATA_WIDTH'(pix(pattern_q, const_q, 8'(x_nxt), 8'(y_nxt)));
            tlast_d = (x_nxt == XW'(IMG_W - 1));
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      pattern_q <= BYPASS;
      const_q   <= '0;
      cont_q    <= 1'b0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      tuser_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      pattern_q <= pattern_d;
      const_q   <= const_d;
      cont_q    <= cont_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      tuser_q   <= tuser_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign busy          = busy_q;
  assign frame_done    = done_q;
endmodule

// File: tb/tb_axis_frame_gen.sv
// Directed bench for axis_frame_gen: a 4x2 instance for protocol scenarios and
// a 16x16 instance for the checkerboard pattern.
module tb_axis_frame_gen;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       continuous = 1'b0;
  logic [1:0] pattern = 2'd0;
  logic [7:0] const_val = 8'd0;
  logic [7:0] tdata;
  logic       tvalid, tlast, busy, frame_done;
  logic [0:0] tuser;
  logic       tready = 1'b1;

  logic       start2 = 1'b0;
  logic [7:0] tdata2;
  logic       tvalid2, tlast2, busy2, frame_done2;
  logic [0:0] tuser2;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] q_data[$];
  logic       q_last[$];
  logic       q_user[$];
  int         done_cnt = 0;
  logic [7:0] pix2 [256];
  int         idx2 = 0;

  always #5 clk = ~clk;

  axis_frame_gen #(.IMG_W(4), .IMG_H(2), .AXIS_TDATA_WIDTH(8), .AXIS_TUSER_WIDTH(1)) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .pattern(pattern),
    .const_val(const_val), .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
    .m_axis_tready(tready), .m_axis_tlast(tlast), .m_axis_tuser(tuser),
    .busy(busy), .frame_done(frame_done)
  );

  axis_frame_gen #(.IMG_W(16), .IMG_H(16), .AXIS_TDATA_WIDTH(8), .AXIS_TUSER_WIDTH(1)) dut_chk (
    .clk(clk), .rst(rst), .start(start2), .continuous(1'b0), .pattern(2'd3),
    .const_val(8'd0), .m_axis_tdata(tdata2), .m_axis_tvalid(tvalid2),
    .m_axis_tready(1'b1), .m_axis_tlast(tlast2), .m_axis_tuser(tuser2),
    .busy(busy2), .frame_done(frame_done2)
  );

  always @(posedge clk) begin
    if (!rst && tvalid && tready) begin
      q_data.push_back(tdata);
      q_last.push_back(tlast);
      q_user.push_back(tuser[0]);
    end
    if (!rst && frame_done) done_cnt++;
    if (!rst && tvalid2 && idx2 < 256) begin
      pix2[idx2] = tdata2;
      idx2++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q_data.delete();
    q_last.delete();
    q_user.delete();
  endtask

  function automatic logic [7:0] exp_pix(input logic [1:0] p, input logic [7:0] cv,
                                         input int x, input int y);
    case (p)
      2'd0:    return cv;
      2'd1:    return 8'(x);
      2'd2:    return 8'(y);
      default: return ((x / 8) % 2 != (y / 8) % 2) ? 8'hFF : 8'h00;
    endcase
  endfunction

  // One 4x2 frame at tready=1; poke pulses start on beat 5 and the last beat.
  task automatic run_frame(input string tag, input logic [1:0] p, input logic [7:0] cv,
                           input bit poke);
    int d0;
    clear_q();
    d0 = done_cnt;
    pattern = p;
    const_val = cv;
    continuous = 1'b0;
    tready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      start = poke && (i == 4 || i == 7);
      check($sformatf("%s_valid%0d", tag, i), tvalid, 1'b1);
      check($sformatf("%s_busy%0d", tag, i), busy, 1'b1);
      check($sformatf("%s_data%0d", tag, i), tdata, exp_pix(p, cv, i % 4, i / 4));
      check($sformatf("%s_last%0d", tag, i), tlast, (i % 4) == 3);
      check($sformatf("%s_user%0d", tag, i), tuser, i == 0);
      check($sformatf("%s_done%0d", tag, i), frame_done, 1'b0);
      tick();
    end
    start = 1'b0;
    check({tag, "_done_end"}, frame_done, 1'b1);
    check({tag, "_valid_end"}, tvalid, 1'b0);
    check({tag, "_busy_end"}, busy, 1'b0);
    tick();
    check({tag, "_done_pulse"}, frame_done, 1'b0);
    check({tag, "_idle"}, tvalid, 1'b0);
    check({tag, "_nbeats"}, q_data.size(), 8);
    check({tag, "_ndone"}, done_cnt - d0, 1);
  endtask

  initial begin
    logic [1:0] rp [4];
    bit         stalled;
    logic [7:0] s_data;
    logic       s_last, s_user;
    int         k, d0;
    rp[0] = 1'b1; rp[1] = 1'b0; rp[2] = 1'b0; rp[3] = 1'b1;

    // Reset state
    tick();
    check("rst_valid", tvalid, 1'b0);
    check("rst_data", tdata, 8'd0);
    check("rst_last", tlast, 1'b0);
    check("rst_user", tuser, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", frame_done, 1'b0);
    rst = 1'b0;

    // Single frame, BOX, start in the first cycle out of reset
    run_frame("s1", 2'd1, 8'h00, 1'b0);

    // Backpressure, solid 8'h5A
    clear_q();
    pattern = 2'd0;
    const_val = 8'h5A;
    tready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    const_val = 8'h33;
    stalled = 1'b0;
    s_data = '0; s_last = 1'b0; s_user = 1'b0;
    k = 0;
    while (!frame_done && k < 64) begin
      if (stalled) begin
        check("s2_hold_valid", tvalid, 1'b1);
        check("s2_hold_data", tdata, s_data);
        check("s2_hold_last", tlast, s_last);
        check("s2_hold_user", tuser, s_user);
      end
      if (tvalid) check("s2_data", tdata, 8'h5A);
      tready = rp[k % 4][0];
      k++;
      stalled = tvalid && !tready;
      s_data = tdata; s_last = tlast; s_user = tuser[0];
      tick();
    end
    check("s2_timeout", frame_done, 1'b1);
    check("s2_nbeats", q_data.size(), 8);
    for (int i = 0; i < q_data.size() && i < 8; i++) begin
      check($sformatf("s2_q_data%0d", i), q_data[i], 8'h5A);
      check($sformatf("s2_q_last%0d", i), q_last[i], (i % 4) == 3);
      check($sformatf("s2_q_user%0d", i), q_user[i], i == 0);
    end
    tready = 1'b1;
    tick();

    // Continuous, GAUSS, cleared during the second frame
    clear_q();
    d0 = done_cnt;
    pattern = 2'd2;
    continuous = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 10) continuous = 1'b0;
      check($sformatf("s3_valid%0d", i), tvalid, 1'b1);
      check($sformatf("s3_data%0d", i), tdata, 8'((i % 8) / 4));
      check($sformatf("s3_user%0d", i), tuser, (i % 8) == 0);
      check($sformatf("s3_done%0d", i), frame_done, i == 8);
      tick();
    end
    check("s3_done_end", frame_done, 1'b1);
    check("s3_valid_end", tvalid, 1'b0);
    check("s3_busy_end", busy, 1'b0);
    tick();
    check("s3_ndone", done_cnt - d0, 2);
    check("s3_nbeats", q_data.size(), 16);
    check("s3_idle", busy, 1'b0);

    // Reset mid-frame during beat 3
    d0 = done_cnt;
    pattern = 2'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("s4_beat3", tdata, 8'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("s4_valid", tvalid, 1'b0);
    check("s4_busy", busy, 1'b0);
    check("s4_done", frame_done, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("s4_quiet%0d", i), tvalid | frame_done, 1'b0);
      tick();
    end
    check("s4_ndone", done_cnt - d0, 0);
    run_frame("s4r", 2'd1, 8'h00, 1'b0);

    // start while busy is ignored
    run_frame("s5", 2'd1, 8'h00, 1'b1);
    tick();
    check("s5_still_idle", tvalid, 1'b0);
    check("s5_still_busy0", busy, 1'b0);

    // Checkerboard on the 16x16 instance
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    k = 0;
    while (!frame_done2 && k < 400) begin
      tick();
      k++;
    end
    check("s6_timeout", frame_done2, 1'b1);
    check("s6_nbeats", idx2, 256);
    check("s6_px_8_0", pix2[8], 8'hFF);
    check("s6_px_8_8", pix2[8 * 16 + 8], 8'h00);
    check("s6_px_0_8", pix2[8 * 16 + 0], 8'hFF);
    check("s6_px_0_0", pix2[0], 8'h00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
